// File: rtl/io_switch_input_port_pkg.sv
// Shared constants for the switch input port: bus window and register offsets.
// Optional debounce is selected with IO_SWITCH_DEBOUNCE_EN (see io_sync_debounce).
package io_port_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'h0000_00C0;
  localparam int          IO_SW_WIDTH  = 10;

  localparam logic [1:0] IO_REG_PORT0  = 2'd0;
  localparam logic [1:0] IO_REG_PORT1  = 2'd1;
  localparam logic [1:0] IO_REG_STATUS = 2'd2;
  localparam logic [1:0] IO_REG_RAW    = 2'd3;

endpackage

// File: rtl/io_switch_input_port_if.sv
// CPU data-memory read path into the switch input port.
// Build option IO_SWITCH_DEBOUNCE_EN does not affect this interface.
interface io_switch_input_port_if;

  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] rd_data;

  modport master (
    output addr,
    output rd_en,
    input  rd_data
  );

  modport slave (
    input  addr,
    input  rd_en,
    output rd_data
  );

endinterface

// File: rtl/io_switch_input_port_sync_debounce.sv
// Two-flop synchronizer plus optional debounce (IO_SWITCH_DEBOUNCE_EN).
// commit_o pulses on the edge where stable_o takes a new value.
module io_sync_debounce #(
  parameter int W         = 10,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic         commit_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] stable_q;
  logic [W-1:0] stable_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
    end
  end

`ifdef IO_SWITCH_DEBOUNCE_EN
  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [W-1:0]  prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
    end
  end

  // Count only while the sampled value holds and differs from stable.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    commit_o = 1'b0;
    if (s2_q == prev_q && s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        commit_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
`else
  localparam int UNUSED_DB_CYCLES = DB_CYCLES;

  always_comb begin
    stable_d = s2_q;
    commit_o = (s2_q != stable_q);
  end
`endif

  assign stable_o = stable_q;

endmodule

// File: rtl/io_switch_input_port.sv
// Memory-mapped switch input port: address decode, read mux, sticky change flag.
// Define IO_SWITCH_DEBOUNCE_EN to enable the debounce counter.
module io_switch_input_port
  import io_port_pkg::*;
#(
  parameter int          SW_WIDTH  = IO_SW_WIDTH,
  parameter int          DB_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   io_in_sw,
  io_switch_input_port_if.slave bus,
  output logic [SW_WIDTH-1:0]   sw_stable,
  output logic                  sw_changed
);

  logic [31:0] rd_q;
  logic [31:0] rd_d;
  logic        chg_q;
  logic        chg_d;
  logic        commit;
  logic        hit;
  logic        clr;
  logic [1:0]  off;
  logic [31:0] raw_w;
  logic        unused_addr;

  io_sync_debounce #(
    .W         (SW_WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) u_sync (
    .clk_i    (clock),
    .rst_i    (reset),
    .raw_i    (io_in_sw),
    .stable_o (sw_stable),
    .commit_o (commit)
  );

  assign raw_w       = 32'(sw_stable);
  assign off         = bus.addr[3:2];
  assign hit         = bus.rd_en && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign unused_addr = ^bus.addr[1:0];

  // A commit on the same edge as a status read leaves the flag set.
  always_comb begin
    rd_d = rd_q;
    clr  = 1'b0;
    if (hit) begin
      unique case (1'b1)
        off == IO_REG_PORT0:  rd_d = {27'b0, raw_w[4:0]};
        off == IO_REG_PORT1:  rd_d = {27'b0, raw_w[9:5]};
        off == IO_REG_STATUS: begin
          rd_d = {31'b0, chg_q};
          clr  = 1'b1;
        end
        default:              rd_d = raw_w;
      endcase
    end
    chg_d = commit | (chg_q & ~clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      chg_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      chg_q <= chg_d;
    end
  end

  assign bus.rd_data = rd_q;
  assign sw_changed  = chg_q;

endmodule
